logic_op_sequencer: RTL

- Issue/writeback stage directly upstream and downstream of the combinational logic-operations unit (AND/OR/XOR/NOT, 3-bit opcode, N-bit operands).
- Accepts commands over a valid/ready handshake and reads two operands from a small local register file.
- Drives registered operands and opcode into the logic unit, captures its output and writes the result back to the register file.
- Reports each result to the host with a one-cycle valid pulse, a zero flag and a wrapping completed-operation counter.

---
 rtl/logic_op_sequencer_pkg.sv | 21 ++
 rtl/logic_regfile.sv | 57 +++++
 rtl/logic_op_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/logic_op_sequencer_pkg.sv
// Shared constants and types for the logic-operation sequencer and its register file.
// No logic; state encoding, opcode values and default widths only.
// Backpressure: not applicable.
package logic_op_sequencer_pkg;

    localparam int N_DEFAULT  = 16;
    localparam int AW_DEFAULT = 2;
    localparam int CNT_W      = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_regfile.sv
// Small register file: two combinational read ports, host and writeback write ports.
// Reads are zero-latency; writes land at the clock edge.
// Backpressure: none; writeback overrides a host write to the same index.
module logic_regfile
    import logic_op_sequencer_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_a_addr,
    output logic [N-1:0]  rd_a_dat,
    input  logic [AW-1:0] rd_b_addr,
    output logic [N-1:0]  rd_b_dat,
    input  logic          wb_vld,
    input  logic [AW-1:0] wb_addr,
    input  logic [N-1:0]  wb_dat,
    input  logic          host_vld,
    input  logic [AW-1:0] host_addr,
    input  logic [N-1:0]  host_dat
);

    localparam int DEPTH = 2 ** AW;

    logic [N-1:0] rf_q [DEPTH];
    logic [N-1:0] rf_d [DEPTH];

    // Writeback is applied after the host write so it wins a collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
            if (host_vld && (host_addr == AW'(i))) begin
                rf_d[i] = host_dat;
            end
            if (wb_vld && (wb_addr == AW'(i))) begin
                rf_d[i] = wb_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign rd_a_dat = rf_q[rd_a_addr];
    assign rd_b_dat = rf_q[rd_b_addr];

endmodule

// File: rtl/logic_op_sequencer.sv
// Issue/writeback sequencer around an external combinational logic unit.
// Latency: result pulse two cycles after acceptance; one command per three cycles.
// Backpressure: cmd_ready is high only in IDLE and never while rst is high.
module logic_op_sequencer
    import logic_op_sequencer_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N-1:0]     wr_data,
    output logic [N-1:0]     lu_a,
    output logic [N-1:0]     lu_b,
    output logic [2:0]       lu_opcode,
    input  logic [N-1:0]     lu_out,
    output logic             res_valid,
    output logic [N-1:0]     res_data,
    output logic [AW-1:0]    res_dst,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count
);

    state_t             state_q, state_d;
    logic [N-1:0]       lu_a_q, lu_a_d;
    logic [N-1:0]       lu_b_q, lu_b_d;
    logic [2:0]         lu_op_q, lu_op_d;
    logic [AW-1:0]      dst_q, dst_d;
    logic [N-1:0]       res_data_q, res_data_d;
    logic [AW-1:0]      res_dst_q, res_dst_d;
    logic               res_zero_q, res_zero_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [N-1:0]       rd_a_dat;
    logic [N-1:0]       rd_b_dat;
    logic               cmd_fire;
    logic               wb_vld;
    logic               host_vld;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wb_vld    = (state_q == ST_WRITE) && !rst;
    assign host_vld  = wr_en && !rst;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_fire) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lu_a_d     = lu_a_q;
        lu_b_d     = lu_b_q;
        lu_op_d    = lu_op_q;
        dst_d      = dst_q;
        res_data_d = res_data_q;
        res_dst_d  = res_dst_q;
        res_zero_d = res_zero_q;
        op_count_d = op_count_q;

        // Operands come from the pre-write register state of the acceptance cycle.
        if (cmd_fire) begin
            lu_a_d  = rd_a_dat;
            lu_b_d  = rd_b_dat;
            lu_op_d = cmd_opcode;
            dst_d   = cmd_dst;
        end

        if (state_q == ST_ISSUE) begin
            res_data_d = lu_out;
            res_dst_d  = dst_q;
            res_zero_d = (lu_out == '0);
        end

        if (state_q == ST_WRITE) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lu_a_q     <= '0;
            lu_b_q     <= '0;
            lu_op_q    <= '0;
            dst_q      <= '0;
            res_data_q <= '0;
            res_dst_q  <= '0;
            res_zero_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            lu_a_q     <= lu_a_d;
            lu_b_q     <= lu_b_d;
            lu_op_q    <= lu_op_d;
            dst_q      <= dst_d;
            res_data_q <= res_data_d;
            res_dst_q  <= res_dst_d;
            res_zero_q <= res_zero_d;
            op_count_q <= op_count_d;
        end
    end

    logic_regfile #(
        .N  (N),
        .AW (AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (cmd_src_a),
        .rd_a_dat  (rd_a_dat),
        .rd_b_addr (cmd_src_b),
        .rd_b_dat  (rd_b_dat),
        .wb_vld    (wb_vld),
        .wb_addr   (dst_q),
        .wb_dat    (res_data_q),
        .host_vld  (host_vld),
        .host_addr (wr_addr),
        .host_dat  (wr_data)
    );

    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign lu_opcode = lu_op_q;
    assign res_valid = wb_vld;
    assign res_data  = res_data_q;
    assign res_dst   = res_dst_q;
    assign res_zero  = res_zero_q;
    assign op_count  = op_count_q;

endmodule
